// File: rtl/axi_mem_pkg.sv
// Shared AXI response codes and FSM state types for the memory responder.
package axi_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RData
  } r_state_e;

endpackage

// File: rtl/axi_mem_responder_rbuf.sv
// Two-entry elastic buffer on the R channel. Capturing the push data into an entry register
// is what makes the RAM read registered; two entries keep full throughput under backpressure.
module axi_mem_responder_rbuf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [Width-1:0] pop_data_o
);

  logic [Width-1:0] data_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign push_ready_o = (cnt_q != 2'd2);
  assign pop_valid_o  = (cnt_q != 2'd0);
  assign pop_data_o   = data_q[rd_ptr_q];
  assign push         = push_valid_i && push_ready_o;
  assign pop          = pop_valid_o && pop_ready_i;

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory slave: INCR bursts of full-width beats served from an inline word RAM.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 64,
  parameter int unsigned           DATA_WIDTH     = 512,
  parameter int unsigned           ID_WIDTH       = 8,
  parameter int unsigned           MEM_WORDS_LOG2 = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           RD_LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rlast,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]              s_axi_rresp
);

  localparam int unsigned StrbW     = DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(StrbW);
  localparam int unsigned LatW      = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned RbufW     = DATA_WIDTH + 3;

  logic [DATA_WIDTH-1:0] mem [2**MEM_WORDS_LOG2];

  // Held low through reset so the address channels only open the cycle after release.
  logic init_q;

  // Write engine state.
  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_beat_q, w_beat_d;
  logic                  w_slverr_q, w_slverr_d;
  logic                  w_decerr_q, w_decerr_d;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_oob;
  logic                  w_last_beat;
  logic                  mem_we;

  // Read engine state; r_issue_q counts beats pushed into the buffer (up to 256).
  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [LatW-1:0]       r_lat_q, r_lat_d;
  logic [8:0]            r_issue_q, r_issue_d;
  logic [ADDR_WIDTH-1:0] r_index;
  logic                  r_oob;
  logic [DATA_WIDTH-1:0] r_word;

  logic                  rb_push;
  logic                  rb_push_ready;
  logic [RbufW-1:0]      rb_push_data;
  logic                  rb_pop_valid;
  logic [RbufW-1:0]      rb_pop_data;

  // Per-beat word index; anything below the base or past the RAM end is out of range.
  assign w_index     = ((w_addr_q - BASE_ADDR) >> ByteShift) + ADDR_WIDTH'(w_beat_q);
  assign w_oob       = (w_addr_q < BASE_ADDR) || ((w_index >> MEM_WORDS_LOG2) != '0);
  assign w_last_beat = (w_beat_q == w_len_q);

  assign r_index     = ((r_addr_q - BASE_ADDR) >> ByteShift) + ADDR_WIDTH'(r_issue_q);
  assign r_oob       = (r_addr_q < BASE_ADDR) || ((r_index >> MEM_WORDS_LOG2) != '0);
  assign r_word      = r_oob ? '0 : mem[r_index[MEM_WORDS_LOG2-1:0]];

  // Reset-release flag for the address channel readies.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Write engine registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_state_q  <= WIdle;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
      w_slverr_q <= 1'b0;
      w_decerr_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_beat_q   <= w_beat_d;
      w_slverr_q <= w_slverr_d;
      w_decerr_q <= w_decerr_d;
    end
  end

  // Write engine next state and AW/W/B outputs; burst length follows awlen, not wlast.
  always_comb begin
    w_state_d     = w_state_q;
    w_id_d        = w_id_q;
    w_addr_d      = w_addr_q;
    w_len_d       = w_len_q;
    w_beat_d      = w_beat_q;
    w_slverr_d    = w_slverr_q;
    w_decerr_d    = w_decerr_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = AXI_RESP_OKAY;
    mem_we        = 1'b0;
    case (w_state_q)
      WIdle: begin
        s_axi_awready = init_q;
        if (init_q && s_axi_awvalid) begin
          w_id_d     = s_axi_awid;
          w_addr_d   = s_axi_awaddr;
          w_len_d    = s_axi_awlen;
          w_beat_d   = 8'd0;
          w_slverr_d = 1'b0;
          w_decerr_d = 1'b0;
          w_state_d  = WData;
        end
      end
      WData: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we   = !w_oob;
          w_beat_d = w_beat_q + 8'd1;
          if (s_axi_wlast != w_last_beat) begin
            w_slverr_d = 1'b1;
          end
          if (w_oob) begin
            w_decerr_d = 1'b1;
          end
          if (w_last_beat) begin
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = w_decerr_q ? AXI_RESP_DECERR :
                       w_slverr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (s_axi_bready) begin
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign s_axi_bid = w_id_q;

  // RAM write port; no reset so contents survive it, and no write while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_index[MEM_WORDS_LOG2-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read engine registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_lat_q   <= '0;
      r_issue_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_lat_q   <= r_lat_d;
      r_issue_q <= r_issue_d;
    end
  end

  // Read engine: wait out the latency, then stream beats into the buffer as space allows.
  // The first push lands on the RD_LATENCY-th edge after the AR fire, so rvalid follows it.
  always_comb begin
    r_state_d     = r_state_q;
    r_id_d        = r_id_q;
    r_addr_d      = r_addr_q;
    r_len_d       = r_len_q;
    r_lat_d       = r_lat_q;
    r_issue_d     = r_issue_q;
    s_axi_arready = 1'b0;
    rb_push       = 1'b0;
    case (r_state_q)
      RIdle: begin
        s_axi_arready = init_q;
        if (init_q && s_axi_arvalid) begin
          r_id_d    = s_axi_arid;
          r_addr_d  = s_axi_araddr;
          r_len_d   = s_axi_arlen;
          r_lat_d   = LatW'(RD_LATENCY - 1);
          r_issue_d = 9'd0;
          r_state_d = RWait;
        end
      end
      RWait: begin
        if (r_lat_q == '0) begin
          rb_push = 1'b1;
          if (rb_push_ready) begin
            r_issue_d = r_issue_q + 9'd1;
            r_state_d = RData;
          end
        end else begin
          r_lat_d = r_lat_q - LatW'(1);
        end
      end
      RData: begin
        rb_push = (r_issue_q <= {1'b0, r_len_q});
        if (rb_push && rb_push_ready) begin
          r_issue_d = r_issue_q + 9'd1;
        end
        // Buffer entry bit 0 is the last-beat flag.
        if (rb_pop_valid && s_axi_rready && rb_pop_data[0]) begin
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign rb_push_data = {r_word,
                         r_oob ? AXI_RESP_DECERR : AXI_RESP_OKAY,
                         (r_issue_q == {1'b0, r_len_q})};

  axi_mem_responder_rbuf #(
    .Width (RbufW)
  ) u_rbuf (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_valid_i (rb_push),
    .push_data_i  (rb_push_data),
    .push_ready_o (rb_push_ready),
    .pop_valid_o  (rb_pop_valid),
    .pop_ready_i  (s_axi_rready),
    .pop_data_o   (rb_pop_data)
  );

  assign s_axi_rvalid = rb_pop_valid;
  assign {s_axi_rdata, s_axi_rresp, s_axi_rlast} = rb_pop_valid ? rb_pop_data : '0;
  assign s_axi_rid    = r_id_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a word model and B/R scoreboards.
module tb_axi_mem_responder;

  localparam logic [63:0] BASE     = 64'h1000;
  localparam logic [63:0] END_ADDR = BASE + 64'd16384;  // 256 words of 64 bytes

  logic         clk = 1'b0;
  logic         reset_n;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awid, awlen, bid, arid, arlen, rid;
  logic [511:0] wdata, rdata;
  logic [63:0]  wstrb;
  logic [1:0]   bresp, rresp;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [7:0]   id;
  } rbeat_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t       rq[$];
  bexp_t        bq[$];
  logic [511:0] mdl [longint unsigned];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .ADDR_WIDTH     (64),
    .DATA_WIDTH     (512),
    .ID_WIDTH       (8),
    .MEM_WORDS_LOG2 (8),
    .BASE_ADDR      (BASE),
    .RD_LATENCY     (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awid    (awid),
    .s_axi_awlen   (awlen),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_bid     (bid),
    .s_axi_bresp   (bresp),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arid    (arid),
    .s_axi_arlen   (arlen),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .s_axi_rid     (rid),
    .s_axi_rresp   (rresp)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [63:0] addr, input int beat);
    return ((addr - BASE) / 64) + 64'(beat);
  endfunction

  function automatic bit oob_of(input logic [63:0] addr, input int beat);
    return (addr < BASE) || (word_of(addr, beat) >= 64'd256);
  endfunction

  // Apply one beat to the reference model under its strobe.
  task automatic mdl_write(input logic [63:0] addr, input int beat, input logic [511:0] d,
                           input logic [63:0] strb);
    logic [63:0]  idx;
    logic [511:0] tmp;
    if (!oob_of(addr, beat)) begin
      idx = word_of(addr, beat);
      tmp = mdl.exists(idx) ? mdl[idx] : '0;
      for (int b = 0; b < 64; b++) begin
        if (strb[b]) tmp[8*b +: 8] = d[8*b +: 8];
      end
      mdl[idx] = tmp;
    end
  endtask

  task automatic wait_ready(input string tag, ref logic sig);
    int n;
    n = 0;
    while (!sig && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk(tag, 512'(0), 512'(1));
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [7:0] id, input int len,
                             input logic [511:0] d0, input logic [63:0] strb, input int wlast_at,
                             input logic [1:0] exp_resp);
    bexp_t be;
    int    n;
    be.id   = id;
    be.resp = exp_resp;
    bq.push_back(be);
    awvalid = 1'b1;
    awaddr  = addr;
    awid    = id;
    awlen   = 8'(len);
    wait_ready("aw_timeout", awready);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1;
      wdata  = d0 + 512'(i);
      wstrb  = strb;
      wlast  = (i == wlast_at);
      wait_ready("w_timeout", wready);
      mdl_write(addr, i, d0 + 512'(i), strb);
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("b_timeout", 512'(0), 512'(1));
    end else begin
      be = bq.pop_front();
      chk("bid", 512'(bid), 512'(be.id));
      chk("bresp", 512'(bresp), 512'(be.resp));
    end
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_drop", 512'(bvalid), 512'(0));
  endtask

  task automatic read_burst(input logic [63:0] addr, input logic [7:0] id, input int len,
                            input bit toggle);
    rbeat_t       e;
    int           n, lat, got, bubbles;
    bit           stalled;
    logic [511:0] hold_d;
    logic [1:0]   hold_r;
    logic         hold_l;
    for (int i = 0; i <= len; i++) begin
      e.data = oob_of(addr, i) ? '0 : mdl[word_of(addr, i)];
      e.resp = oob_of(addr, i) ? 2'b11 : 2'b00;
      e.last = (i == len);
      e.id   = id;
      rq.push_back(e);
    end
    arvalid = 1'b1;
    araddr  = addr;
    arid    = id;
    arlen   = 8'(len);
    rready  = !toggle;
    wait_ready("ar_timeout", arready);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("r_latency", 512'(lat), 512'(2));
    got     = 0;
    n       = 0;
    bubbles = 0;
    stalled = 1'b0;
    hold_d  = '0;
    hold_r  = '0;
    hold_l  = 1'b0;
    while (got <= len && n < 200) begin
      if (toggle) rready = ~rready;
      if (stalled) begin
        chk("r_stall_valid", 512'(rvalid), 512'(1));
        chk("r_stall_data", rdata, hold_d);
        chk("r_stall_resp", 512'(rresp), 512'(hold_r));
        chk("r_stall_last", 512'(rlast), 512'(hold_l));
      end
      if (rvalid) begin
        if (rready) begin
          if (rq.size() == 0) begin
            chk("r_extra_beat", 512'(1), 512'(0));
          end else begin
            e = rq.pop_front();
            chk("rdata", rdata, e.data);
            chk("rresp", 512'(rresp), 512'(e.resp));
            chk("rlast", 512'(rlast), 512'(e.last));
            chk("rid", 512'(rid), 512'(e.id));
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = rdata;
          hold_r  = rresp;
          hold_l  = rlast;
        end
      end else begin
        bubbles++;
        stalled = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("r_timeout", 512'(got), 512'(len + 1));
    if (!toggle) chk("r_bubbles", 512'(bubbles), 512'(0));
    chk("rvalid_after_last", 512'(rvalid), 512'(0));
    chk("arready_after_last", 512'(arready), 512'(1));
    chk("r_queue_empty", 512'(rq.size()), 512'(0));
    rready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;
    reset_n = 1'b0;
    awvalid = 1'b0;
    awaddr  = '0;
    awid    = '0;
    awlen   = '0;
    wvalid  = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    arid    = '0;
    arlen   = '0;
    rready  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_awready", 512'(awready), 512'(0));
    chk("rst_arready", 512'(arready), 512'(0));
    chk("rst_wready", 512'(wready), 512'(0));
    chk("rst_bvalid", 512'(bvalid), 512'(0));
    chk("rst_rvalid", 512'(rvalid), 512'(0));
    chk("rst_rlast", 512'(rlast), 512'(0));
    chk("rst_bresp", 512'(bresp), 512'(0));
    chk("rst_rresp", 512'(rresp), 512'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_awready", 512'(awready), 512'(1));
    chk("rel_arready", 512'(arready), 512'(1));

    // 1: four-beat write then read back.
    write_burst(BASE + 64'h40, 8'h11, 3, 512'hA0, '1, 3, 2'b00);
    read_burst(BASE + 64'h40, 8'h22, 3, 1'b0);

    // 2: partial strobe over an all-ones word.
    write_burst(BASE + 64'h100, 8'h33, 0, {512{1'b1}}, '1, 0, 2'b00);
    write_burst(BASE + 64'h100, 8'h34, 0, '0, 64'hF, 0, 2'b00);
    read_burst(BASE + 64'h100, 8'h35, 0, 1'b0);

    // 3: early wlast still writes all beats, flagged SLVERR.
    write_burst(BASE + 64'h200, 8'h44, 3, 512'hC0, '1, 1, 2'b10);
    read_burst(BASE + 64'h200, 8'h45, 3, 1'b0);

    // 4: out-of-range accesses; word 0 must not be aliased by the write past the end.
    write_burst(BASE, 8'h50, 0, 512'hDEAD, '1, 0, 2'b00);
    read_burst(END_ADDR, 8'h51, 0, 1'b0);
    write_burst(END_ADDR, 8'h52, 0, 512'hBAD, '1, 0, 2'b11);
    read_burst(BASE, 8'h53, 0, 1'b0);
    read_burst(BASE - 64'd64, 8'h54, 0, 1'b0);
    write_burst(END_ADDR - 64'd64, 8'h56, 1, 512'hE0, '1, 1, 2'b11);
    read_burst(END_ADDR - 64'd64, 8'h57, 1, 1'b0);

    // 5: eight beats under toggling rready.
    write_burst(BASE + 64'h400, 8'h60, 7, 512'h70, '1, 7, 2'b00);
    read_burst(BASE + 64'h400, 8'h61, 7, 1'b1);

    // 6: reset after two of four write beats.
    awvalid = 1'b1;
    awaddr  = BASE + 64'h800;
    awid    = 8'h70;
    awlen   = 8'd3;
    wait_ready("aw6_timeout", awready);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1;
      wdata  = 512'hF0 + 512'(i);
      wstrb  = '1;
      wlast  = 1'b0;
      wait_ready("w6_timeout", wready);
      mdl_write(BASE + 64'h800, i, 512'hF0 + 512'(i), '1);
      @(negedge clk);
    end
    wvalid  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_wready", 512'(wready), 512'(0));
    chk("abort_bvalid", 512'(bvalid), 512'(0));
    chk("abort_awready_in_reset", 512'(awready), 512'(0));
    reset_n = 1'b1;
    bready  = 1'b1;
    @(negedge clk);
    chk("abort_awready_after", 512'(awready), 512'(1));
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      if (bvalid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_bvalid", 512'(seen), 512'(0));
    bready = 1'b0;
    read_burst(BASE + 64'h800, 8'h71, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
